// File: rtl/pipe_pkg.sv
// Shared pipeline types: stage occupancy states, default widths and the
// per-stage control bundles that size each pipe_stage_reg instance.
package pipe_pkg;

   localparam int WORD_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

   typedef struct packed {
      logic       alu_src;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic mem_to_reg;
      logic reg_write;
      logic mem_write;
      logic mem_read;
   } ex_mem_ctrl_t;

   typedef struct packed {
      logic mem_to_reg;
      logic reg_write;
   } mem_wb_ctrl_t;

   localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);

   function automatic logic holds_entry(input stage_state_t s);
      return s != EMPTY;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a one-entry skid buffer, flush to
// bubbles and a starvation (bubble) counter for profiling.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W     = WORD_W,
   parameter int CTRL_W     = EX_MEM_CTRL_W,
   parameter bit CLEAR_DATA = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              stat_clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_count
);

   stage_state_t      state;
   stage_state_t      state_next;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              accept;
   logic              emit;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid;

   assign out_valid = holds_entry(state);
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;

   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  load_main_in = 1'b1;
                  state_next   = ONE;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  load_skid  = 1'b1;
                  state_next = FULL;
               end else if (emit) begin
                  state_next = EMPTY;
               end
            end
            FULL: begin
               if (emit) begin
                  load_main_skid = 1'b1;
                  state_next     = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // The head register drives the outputs directly, so an empty stage is
   // turned into a bubble by clearing the head as it drains.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_ctrl  <= '0;
         out_data  <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         state    <= state_next;
         in_ready <= (state_next != FULL);

         if (state_next == EMPTY) begin
            out_ctrl <= '0;
            if (CLEAR_DATA) out_data <= '0;
         end else if (load_main_in) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
         end else if (load_main_skid) begin
            out_ctrl <= skid_ctrl;
            out_data <= skid_data;
         end

         if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
         end else if (state_next != FULL) begin
            skid_ctrl <= '0;
            if (CLEAR_DATA) skid_data <= '0;
         end
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_bubble_counter (
      .clk  (clk),
      .reset(reset),
      .inc  (out_ready & ~out_valid),
      .clr  (stat_clear),
      .count(bubble_count)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: stimulus pushes expected entries into a
// scoreboard queue that an independent monitor drains on every emit.
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        stat_clear;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_ctrl;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_ctrl;
   logic [31:0] out_data;
   logic [3:0]  bubble_count;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   pipe_stage_reg #(
      .DATA_W    (32),
      .CTRL_W    (4),
      .CLEAR_DATA(1'b1),
      .CNT_W     (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .stat_clear  (stat_clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ctrl     (in_ctrl),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ctrl    (out_ctrl),
      .out_data    (out_data),
      .bubble_count(bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [3:0] c, input logic [31:0] d);
      in_valid = 1'b1;
      in_ctrl  = c;
      in_data  = d;
   endtask

   task automatic expect_entry(input logic [3:0] c, input logic [31:0] d);
      exp_t e;
      e.ctrl = c;
      e.data = d;
      sb.push_back(e);
   endtask

   // Inputs only change just after posedge, so a negedge view of
   // valid & ready is exactly what the next edge will transfer.
   always @(negedge clk) begin
      exp_t e;
      if (reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sb_unexpected: got ctrl=%0h data=%0h expected no entry",
                     out_ctrl, out_data);
         end else begin
            e = sb.pop_front();
            check_output("sb_ctrl", 64'(out_ctrl), 64'(e.ctrl));
            check_output("sb_data", 64'(out_data), 64'(e.data));
         end
      end
      if (reset && !out_valid) begin
         check_output("bubble_ctrl", 64'(out_ctrl), 64'd0);
         check_output("bubble_data", 64'(out_data), 64'd0);
      end
   end

   initial begin
      reset      = 1'b0;
      flush      = 1'b0;
      stat_clear = 1'b0;
      in_valid   = 1'b0;
      in_ctrl    = '0;
      in_data    = '0;
      out_ready  = 1'b0;

      // Reset state, then build a FULL stage and assert reset mid-cycle.
      step(2);
      reset = 1'b1;
      check_output("rst_out_valid", 64'(out_valid), 64'd0);
      check_output("rst_in_ready", 64'(in_ready), 64'd1);
      check_output("rst_count", 64'(bubble_count), 64'd0);
      out_ready = 1'b1;
      step(3);
      check_output("idle_count", 64'(bubble_count), 64'd3);
      out_ready = 1'b0;
      present(4'h1, 32'hAAAA_0001);
      step(1);
      present(4'h2, 32'hAAAA_0002);
      step(1);
      in_valid = 1'b0;
      check_output("full_out_valid", 64'(out_valid), 64'd1);
      check_output("full_in_ready", 64'(in_ready), 64'd0);
      check_output("full_head", 64'(out_data), 64'hAAAA_0001);
      #2;
      reset = 1'b0;
      #1;
      check_output("async_out_valid", 64'(out_valid), 64'd0);
      check_output("async_in_ready", 64'(in_ready), 64'd1);
      check_output("async_out_ctrl", 64'(out_ctrl), 64'd0);
      check_output("async_out_data", 64'(out_data), 64'd0);
      check_output("async_count", 64'(bubble_count), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Streaming 1..8 at full rate.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         present(4'(i), 32'(i));
         expect_entry(4'(i), 32'(i));
         check_output("stream_in_ready", 64'(in_ready), 64'd1);
         step(1);
         check_output("stream_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      step(2);
      check_output("stream_drain", 64'(sb.size()), 64'd0);

      // Back-pressure fills main and skid, third entry stalls upstream.
      out_ready = 1'b0;
      expect_entry(4'h3, 32'h10);
      expect_entry(4'h5, 32'h11);
      expect_entry(4'h9, 32'h12);
      present(4'h3, 32'h10);
      step(1);
      present(4'h5, 32'h11);
      step(1);
      present(4'h9, 32'h12);
      check_output("bp_in_ready_full", 64'(in_ready), 64'd0);
      step(1);
      check_output("bp_stall_ready", 64'(in_ready), 64'd0);
      check_output("bp_head_held", 64'(out_data), 64'h10);
      out_ready = 1'b1;
      step(1);
      check_output("bp_ready_again", 64'(in_ready), 64'd1);
      check_output("bp_skid_to_head", 64'(out_data), 64'h11);
      step(1);
      in_valid = 1'b0;
      check_output("bp_third_head", 64'(out_data), 64'h12);
      step(2);
      check_output("bp_drain", 64'(sb.size()), 64'd0);

      // Flush while FULL with a new entry on the input.
      out_ready = 1'b0;
      present(4'h6, 32'h20);
      step(1);
      present(4'h7, 32'h21);
      step(1);
      present(4'hF, 32'h99);
      flush = 1'b1;
      check_output("fl_pre_in_ready", 64'(in_ready), 64'd0);
      step(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      check_output("fl_out_valid", 64'(out_valid), 64'd0);
      check_output("fl_out_ctrl", 64'(out_ctrl), 64'd0);
      check_output("fl_out_data", 64'(out_data), 64'd0);
      check_output("fl_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      step(3);
      check_output("fl_nothing_left", 64'(sb.size()), 64'd0);

      // Flush together with emit (and an accepted entry) in ONE.
      out_ready = 1'b0;
      present(4'hC, 32'h55);
      expect_entry(4'hC, 32'h55);
      step(1);
      out_ready = 1'b1;
      flush     = 1'b1;
      present(4'hD, 32'h66);
      check_output("fe_head", 64'(out_data), 64'h55);
      step(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      check_output("fe_out_valid", 64'(out_valid), 64'd0);
      check_output("fe_in_ready", 64'(in_ready), 64'd1);
      check_output("fe_delivered", 64'(sb.size()), 64'd0);
      step(2);

      // Bubble counter: clear beats increment, saturation at 15, flush independence.
      out_ready  = 1'b1;
      stat_clear = 1'b1;
      step(1);
      stat_clear = 1'b0;
      check_output("cnt_clear", 64'(bubble_count), 64'd0);
      step(5);
      check_output("cnt_five", 64'(bubble_count), 64'd5);
      step(15);
      check_output("cnt_saturate", 64'(bubble_count), 64'd15);
      stat_clear = 1'b1;
      step(1);
      stat_clear = 1'b0;
      check_output("cnt_clear_again", 64'(bubble_count), 64'd0);
      step(1);
      check_output("cnt_restart", 64'(bubble_count), 64'd1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      check_output("cnt_flush_indep", 64'(bubble_count), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
